// File: rtl/vad_decision_smoother_pkg.sv
// Shared definitions for the VAD decision smoother: classifier codes and FSM states.
package vad_decision_smoother_pkg;

  localparam logic [1:0] CLS_NONE    = 2'b00;
  localparam logic [1:0] CLS_NOISE   = 2'b01;
  localparam logic [1:0] CLS_SPEECH  = 2'b10;
  localparam logic [1:0] CLS_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_NOISE  = 2'd0,
    ST_ONSET  = 2'd1,
    ST_SPEECH = 2'd2,
    ST_HANG   = 2'd3
  } vad_state_e;

  // Only speech and noise codes count as frames; 00 and 11 never advance anything.
  function automatic logic is_frame_code(input logic [1:0] code);
    return (code == CLS_SPEECH) || (code == CLS_NOISE);
  endfunction

endpackage

// File: rtl/vad_decision_smoother_slot.sv
// vad_out_slot: single-entry valid/ready holding register with sticky overflow flag.
module vad_out_slot #(
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic               load_flag,
  input  logic [FRAME_W-1:0] load_frame,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_flag,
  output logic [FRAME_W-1:0] out_frame,
  output logic               ovf
);

  logic               valid_q, valid_d;
  logic               flag_q, flag_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               ovf_q, ovf_d;

  always_comb begin
    valid_d = valid_q;
    flag_d  = flag_q;
    frame_d = frame_q;
    ovf_d   = ovf_q;
    if (load_valid) begin
      // A load coinciding with a drain simply replaces the entry.
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        flag_d  = load_flag;
        frame_d = load_frame;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
      frame_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      flag_q  <= flag_d;
      frame_q <= frame_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_flag  = flag_q;
  assign out_frame = frame_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/vad_decision_smoother.sv
// Debounces per-frame speech/noise classes into a VAD flag (onset + hangover)
// and presents one decision per frame through a single-entry valid/ready slot.
module vad_decision_smoother
  import vad_decision_smoother_pkg::*;
#(
  parameter int ONSET_FRAMES = 2,
  parameter int HANG_FRAMES  = 8,
  parameter int FRAME_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cls_valid,
  input  logic [1:0]         cls_in,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic               dec_flag,
  output logic [FRAME_W-1:0] dec_frame,
  output logic               vad_flag,
  output logic               err_illegal,
  output logic               err_ovf
);

  localparam int CNT_MAX = (ONSET_FRAMES > HANG_FRAMES) ? ONSET_FRAMES : HANG_FRAMES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ONSET_C = CNT_W'(ONSET_FRAMES);
  localparam logic [CNT_W-1:0] HANG_C  = CNT_W'(HANG_FRAMES);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  vad_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [FRAME_W-1:0] idx_q, idx_d;
  logic               vad_q, vad_d;
  logic               ill_q, ill_d;
  logic               frame, speech;

  assign frame   = cls_valid && is_frame_code(cls_in);
  assign speech  = (cls_in == CLS_SPEECH);
  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame) begin
      unique case (state_q)
        ST_NOISE: begin
          if (speech) begin
            if (ONSET_FRAMES == 1) begin
              state_d = ST_SPEECH;
            end else begin
              state_d = ST_ONSET;
              cnt_d   = ONE_C;
            end
          end
        end
        ST_ONSET: begin
          if (speech) begin
            cnt_d = cnt_inc;
            if (cnt_inc == ONSET_C) begin
              state_d = ST_SPEECH;
              cnt_d   = '0;
            end
          end else begin
            state_d = ST_NOISE;
            cnt_d   = '0;
          end
        end
        ST_SPEECH: begin
          if (!speech) begin
            if (HANG_FRAMES == 0) begin
              state_d = ST_NOISE;
            end else begin
              state_d = ST_HANG;
              cnt_d   = ONE_C;
            end
          end
        end
        ST_HANG: begin
          if (speech) begin
            state_d = ST_SPEECH;
            cnt_d   = '0;
          end else if (cnt_q == HANG_C) begin
            state_d = ST_NOISE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_NOISE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The decision carries the flag as it will be after this frame, hence state_d.
  always_comb begin
    vad_d = (state_d == ST_SPEECH) || (state_d == ST_HANG);
    idx_d = frame ? idx_q + FRAME_W'(1) : idx_q;
    ill_d = ill_q || (cls_valid && (cls_in == CLS_ILLEGAL));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_NOISE;
      cnt_q   <= '0;
      idx_q   <= '0;
      vad_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vad_q   <= vad_d;
      ill_q   <= ill_d;
    end
  end

  vad_out_slot #(
    .FRAME_W(FRAME_W)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(frame),
    .load_flag (vad_d),
    .load_frame(idx_q),
    .out_ready (dec_ready),
    .out_valid (dec_valid),
    .out_flag  (dec_flag),
    .out_frame (dec_frame),
    .ovf       (err_ovf)
  );

  assign vad_flag    = vad_q;
  assign err_illegal = ill_q;

endmodule

// File: tb/tb_vad_decision_smoother.sv
// Bench for vad_decision_smoother: two parameterisations driven in lockstep, checked
// every cycle against a run-length model, plus directed literal expectations.
module tb_vad_decision_smoother;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cls_valid = 1'b0;
  logic [1:0] cls_in = 2'b00;
  logic dec_ready = 1'b1;

  logic        a_valid, a_flag, a_vad, a_ill, a_ovf;
  logic [15:0] a_frame;
  logic        b_valid, b_flag, b_vad, b_ill, b_ovf;
  logic [3:0]  b_frame;

  always #5 clk = ~clk;

  vad_decision_smoother dut_a (
    .clk(clk), .rst_n(rst_n), .cls_valid(cls_valid), .cls_in(cls_in),
    .dec_valid(a_valid), .dec_ready(dec_ready), .dec_flag(a_flag), .dec_frame(a_frame),
    .vad_flag(a_vad), .err_illegal(a_ill), .err_ovf(a_ovf)
  );

  vad_decision_smoother #(.ONSET_FRAMES(1), .HANG_FRAMES(0), .FRAME_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .cls_valid(cls_valid), .cls_in(cls_in),
    .dec_valid(b_valid), .dec_ready(dec_ready), .dec_flag(b_flag), .dec_frame(b_frame),
    .vad_flag(b_vad), .err_illegal(b_ill), .err_ovf(b_ovf)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit armed = 0;

  // Model: the flag rises once the current speech run reaches ONSET frames and
  // falls once the current noise run exceeds HANG frames.
  int onset_p[2] = '{2, 1};
  int hang_p[2]  = '{8, 0};
  int mask_p[2]  = '{16'hFFFF, 4'hF};
  int m_srun[2], m_nrun[2], m_idx[2], m_sframe[2];
  bit m_flag[2], m_sv[2], m_sflag[2], m_ovf[2];
  bit m_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (!armed) return;
    chk("a_vad", a_vad, m_flag[0]);
    chk("a_valid", a_valid, m_sv[0]);
    chk("a_ill", a_ill, m_ill);
    chk("a_ovf", a_ovf, m_ovf[0]);
    if (m_sv[0]) begin
      chk("a_flag", a_flag, m_sflag[0]);
      chk("a_frame", a_frame, m_sframe[0]);
    end
    chk("b_vad", b_vad, m_flag[1]);
    chk("b_valid", b_valid, m_sv[1]);
    chk("b_ill", b_ill, m_ill);
    chk("b_ovf", b_ovf, m_ovf[1]);
    if (m_sv[1]) begin
      chk("b_flag", b_flag, m_sflag[1]);
      chk("b_frame", b_frame, m_sframe[1]);
    end
  endtask

  task automatic model_update(input bit rn, input bit v, input logic [1:0] c, input bit r);
    bit frame;
    if (!rn) begin
      armed = 1;
      m_ill = 0;
      for (int k = 0; k < 2; k++) begin
        m_srun[k] = 0; m_nrun[k] = 0; m_idx[k] = 0; m_sframe[k] = 0;
        m_flag[k] = 0; m_sv[k] = 0; m_sflag[k] = 0; m_ovf[k] = 0;
      end
      return;
    end
    if (v && c == 2'b11) m_ill = 1;
    frame = v && (c == 2'b10 || c == 2'b01);
    for (int k = 0; k < 2; k++) begin
      if (frame) begin
        if (c == 2'b10) begin m_srun[k]++; m_nrun[k] = 0; end
        else begin m_nrun[k]++; m_srun[k] = 0; end
        if (m_flag[k]) m_flag[k] = !(m_nrun[k] > hang_p[k]);
        else m_flag[k] = (m_srun[k] >= onset_p[k]);
        if (!m_sv[k] || r) begin
          m_sv[k] = 1; m_sflag[k] = m_flag[k]; m_sframe[k] = m_idx[k];
        end else begin
          m_ovf[k] = 1;
        end
        m_idx[k] = (m_idx[k] + 1) & mask_p[k];
      end else if (m_sv[k] && r) begin
        m_sv[k] = 0;
      end
    end
  endtask

  // One clock cycle: check what the last edge produced, then drive the next inputs.
  task automatic step(input bit rn, input bit v, input logic [1:0] c, input bit r);
    @(negedge clk);
    compare_all();
    rst_n = rn; cls_valid = v; cls_in = c; dec_ready = r;
    model_update(rn, v, c, r);
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_s(input bit r); step(1, 1, 2'b10, r); endtask
  task automatic frame_n(input bit r); step(1, 1, 2'b01, r); endtask

  initial begin
    logic [1:0] c;
    step(0, 0, 2'b00, 1);
    step(0, 0, 2'b00, 1);

    // Idle after reset: everything quiet.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 2'b00, 1);
      if (i == 19) begin
        peek();
        chk("idle_outputs", {a_valid, a_vad, a_ill, a_ovf, b_valid, b_vad}, 6'b0);
      end
    end

    // S,N,S,S -> flags 0,0,0,1 on frames 0..3.
    frame_s(1); peek(); chk("sns_flag0", a_flag, 0); chk("sns_frame0", a_frame, 0);
    frame_n(1); peek(); chk("sns_flag1", a_flag, 0); chk("sns_frame1", a_frame, 1);
    frame_s(1); peek(); chk("sns_flag2", a_flag, 0); chk("sns_frame2", a_frame, 2);
    frame_s(1); peek(); chk("sns_flag3", a_flag, 1); chk("sns_frame3", a_frame, 3);

    // Hangover: 8 noise frames keep the flag, the 9th releases it.
    for (int i = 1; i <= 9; i++) begin
      frame_n(1); peek();
      chk($sformatf("hang_n%0d", i), a_vad, (i <= 8) ? 1 : 0);
    end
    frame_s(1); frame_s(1); peek(); chk("reonset", a_vad, 1);
    for (int i = 0; i < 5; i++) frame_n(1);
    frame_s(1); peek(); chk("hang_interrupt", a_vad, 1);
    for (int i = 1; i <= 9; i++) begin
      frame_n(1); peek();
      chk($sformatf("hang_restart_n%0d", i), a_vad, (i <= 8) ? 1 : 0);
    end

    // 00 produces no decision; 11 is flagged.
    step(1, 1, 2'b00, 1); peek(); chk("none_no_valid", a_valid, 0);
    step(1, 1, 2'b11, 1); peek(); chk("illegal_sticky", a_ill, 1); chk("illegal_no_valid", a_valid, 0);

    // Reset during hangover.
    frame_s(1); frame_s(1); frame_n(1); frame_n(1); peek(); chk("pre_rst_hang", a_vad, 1);
    step(0, 1, 2'b10, 0); peek();
    chk("rst_mid_hang", {a_vad, a_valid, a_ill, a_ovf}, 4'b0);

    // Backpressure: coincident frame+ready reloads; a frame into a full slot drops.
    frame_s(0); peek(); chk("bp_first", a_frame, 0);
    frame_n(1); peek(); chk("bp_reload_frame", a_frame, 1); chk("bp_reload_ovf", a_ovf, 0);
    frame_n(0); peek(); chk("bp_drop_ovf", a_ovf, 1); chk("bp_hold_frame", a_frame, 1);
    chk("bp_hold_valid", a_valid, 1);

    // Short index wraps and the no-debounce variant follows the raw class.
    step(0, 0, 2'b00, 1);
    for (int i = 0; i < 17; i++) begin
      c = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      step(1, 1, c, 1); peek();
      chk($sformatf("wrap_frame%0d", i), b_frame, i & 15);
      chk($sformatf("follow%0d", i), b_vad, (c == 2'b10) ? 1 : 0);
    end

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6) c = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'b01;
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), c,
           ($urandom_range(0, 3) != 0));
    end
    step(1, 0, 2'b00, 1);
    step(1, 0, 2'b00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
